// File: rtl/alu_flags_unit.sv
// Execute-stage ALU with condition check, NZCV flags register and registered address mux.
// Optional multiplier on opcode 3 is enabled by defining ALU_MUL_EN.
module alu_flags_unit #(
  parameter int DW = 32,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in1,
  input  logic [DW-1:0] in2,
  input  logic          sbit,
  input  logic [3:0]    cond,
  input  logic [3:0]    opcode,
  input  logic [2:0]    srcontrol,
  input  logic [15:0]   imvalue,
  output logic [DW-1:0] result,
  output logic          exec,
  output logic [3:0]    flags,
  input  logic          sel_add_bus,
  input  logic [AW-1:0] address_add_bus_in,
  output logic [AW-1:0] address_out
);

  localparam logic [3:0] OP_NOP  = 4'h0, OP_ADD  = 4'h1, OP_SUB  = 4'h2, OP_MUL  = 4'h3,
                         OP_ORR  = 4'h4, OP_AND  = 4'h5, OP_EOR  = 4'h6, OP_MOV  = 4'h7,
                         OP_LDR  = 4'h8, OP_STR  = 4'h9, OP_SHF  = 4'hA, OP_CMP  = 4'hB,
                         OP_ADDI = 4'hC, OP_SUBI = 4'hD, OP_MVN  = 4'hE;

  logic          f_n, f_z, f_c, f_v;
  logic          cond_pass;
  logic [DW-1:0] imm;
  logic [DW-1:0] op2;
  logic [DW:0]   sum_w, diff_w;
  logic [4:0]    amt;
  logic [DW:0]   lsl_w, lsr_w, asr_w;
  logic [DW-1:0] ror_w;
  logic [DW-1:0] alu_r;
  logic          c_new, v_new;
  logic          op_valid, op_flags;
  logic          flag_we;

  assign {f_n, f_z, f_c, f_v} = flags;
  assign imm = {{(DW-16){1'b0}}, imvalue};

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'h0: cond_pass = f_z;
      4'h1: cond_pass = !f_z;
      4'h2: cond_pass = f_c;
      4'h3: cond_pass = !f_c;
      4'h4: cond_pass = f_n;
      4'h5: cond_pass = !f_n;
      4'h6: cond_pass = f_v;
      4'h7: cond_pass = !f_v;
      4'h8: cond_pass = f_c && !f_z;
      4'h9: cond_pass = !f_c || f_z;
      4'hA: cond_pass = (f_n == f_v);
      4'hB: cond_pass = (f_n != f_v);
      4'hC: cond_pass = !f_z && (f_n == f_v);
      4'hD: cond_pass = f_z || (f_n != f_v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Immediate forms share the adder/subtractor with the register forms.
  assign op2    = (opcode == OP_ADDI || opcode == OP_SUBI) ? imm : in2;
  assign sum_w  = {1'b0, in1} + {1'b0, op2};
  assign diff_w = {1'b0, in1} - {1'b0, op2};

  // Widened shifts keep the last bit shifted out in the extra position.
  assign amt   = srcontrol[2] ? imvalue[4:0] : in2[4:0];
  assign lsl_w = {1'b0, in1} << amt;
  assign lsr_w = {in1, 1'b0} >> amt;
  assign asr_w = $signed({in1, 1'b0}) >>> amt;
  assign ror_w = (in1 >> amt) | (in1 << (DW - int'(amt)));

  always_comb begin
    alu_r    = '0;
    c_new    = f_c;
    v_new    = f_v;
    op_valid = 1'b1;
    op_flags = 1'b1;
    case (opcode)
      OP_NOP: op_flags = 1'b0;
      OP_ADD, OP_ADDI: begin
        alu_r = sum_w[DW-1:0];
        c_new = sum_w[DW];
        v_new = (in1[DW-1] == op2[DW-1]) && (alu_r[DW-1] != in1[DW-1]);
      end
      OP_SUB, OP_SUBI, OP_CMP: begin
        alu_r = diff_w[DW-1:0];
        c_new = !diff_w[DW];
        v_new = (in1[DW-1] != op2[DW-1]) && (alu_r[DW-1] != in1[DW-1]);
      end
`ifdef ALU_MUL_EN
      OP_MUL: alu_r = in1 * in2;
`else
      OP_MUL: begin
        op_valid = 1'b0;
        op_flags = 1'b0;
      end
`endif
      OP_ORR: alu_r = in1 | in2;
      OP_AND: alu_r = in1 & in2;
      OP_EOR: alu_r = in1 ^ in2;
      OP_MOV: alu_r = imm;
      OP_LDR, OP_STR: begin
        alu_r    = in1;
        op_flags = 1'b0;
      end
      OP_SHF: begin
        if (amt == 5'd0) begin
          alu_r = in1;
        end else begin
          case (srcontrol[1:0])
            2'b00:   {c_new, alu_r} = lsl_w;
            2'b01:   {alu_r, c_new} = lsr_w;
            2'b10:   {alu_r, c_new} = asr_w;
            default: begin
              alu_r = ror_w;
              c_new = ror_w[DW-1];
            end
          endcase
        end
      end
      OP_MVN: alu_r = ~in2;
      default: begin
        op_valid = 1'b0;
        op_flags = 1'b0;
      end
    endcase
  end

  assign result  = cond_pass ? alu_r : '0;
  assign exec    = cond_pass && op_valid && (opcode != OP_CMP);
  assign flag_we = cond_pass && op_valid && op_flags && (sbit || opcode == OP_CMP);

  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= 4'b0000;
    end else if (flag_we) begin
      flags <= {alu_r[DW-1], (alu_r == '0), c_new, v_new};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      address_out <= '0;
    end else if (sel_add_bus) begin
      address_out <= address_add_bus_in;
    end
  end

endmodule

// File: tb/tb_alu_flags_unit.sv
// Self-checking bench for alu_flags_unit: directed vectors plus randomized ops vs a reference model.
module tb_alu_flags_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in1, in2;
  logic        sbit;
  logic [3:0]  cond, opcode;
  logic [2:0]  srcontrol;
  logic [15:0] imvalue;
  logic [31:0] result;
  logic        exec;
  logic [3:0]  flags;
  logic        sel_add_bus;
  logic [15:0] address_add_bus_in;
  logic [15:0] address_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0]  mf;
  logic [15:0] ma;
  logic [31:0] er;
  logic        ee;
  logic [3:0]  enf;

  alu_flags_unit #(.DW(32), .AW(16)) dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .sbit(sbit), .cond(cond),
    .opcode(opcode), .srcontrol(srcontrol), .imvalue(imvalue), .result(result),
    .exec(exec), .flags(flags), .sel_add_bus(sel_add_bus),
    .address_add_bus_in(address_add_bus_in), .address_out(address_out)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [3:0] op, input logic [3:0] cnd, input logic sb,
                                input logic [2:0] sc, input logic [15:0] imv,
                                input logic [31:0] a, input logic [31:0] b, input logic [3:0] f,
                                output logic [31:0] r, output logic e, output logic [3:0] nf);
    logic n, z, c, v, pass, valid, wf, nc, nv;
    logic [31:0] imm, o2;
    longint s, u;
    int amt;
    {n, z, c, v} = f;
    case (cnd)
      0: pass = z;          1: pass = !z;         2: pass = c;          3: pass = !c;
      4: pass = n;          5: pass = !n;         6: pass = v;          7: pass = !v;
      8: pass = c && !z;    9: pass = !c || z;    10: pass = n == v;    11: pass = n != v;
      12: pass = !z && n == v; 13: pass = z || n != v; 14: pass = 1;   default: pass = 0;
    endcase
    imm = {16'h0, imv};
    o2 = (op == 4'hC || op == 4'hD) ? imm : b;
    r = 0; valid = 1; wf = 1; nc = c; nv = v;
    case (op)
      4'h0: wf = 0;
      4'h1, 4'hC: begin
        u = longint'(a) + longint'(o2);
        r = u[31:0]; nc = u[32];
        s = longint'($signed(a)) + longint'($signed(o2));
        nv = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h2, 4'hD, 4'hB: begin
        r = a - o2; nc = (a >= o2);
        s = longint'($signed(a)) - longint'($signed(o2));
        nv = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h3: begin
`ifdef ALU_MUL_EN
        r = a * b;
`else
        valid = 0; wf = 0;
`endif
      end
      4'h4: r = a | b;
      4'h5: r = a & b;
      4'h6: r = a ^ b;
      4'h7: r = imm;
      4'h8, 4'h9: begin r = a; wf = 0; end
      4'hA: begin
        amt = sc[2] ? int'(imv[4:0]) : int'(b[4:0]);
        if (amt == 0) r = a;
        else begin
          case (sc[1:0])
            0: begin r = a << amt; nc = a[32-amt]; end
            1: begin r = a >> amt; nc = a[amt-1]; end
            2: begin r = $signed(a) >>> amt; nc = a[amt-1]; end
            default: begin r = (a >> amt) | (a << (32 - amt)); nc = r[31]; end
          endcase
        end
      end
      4'hE: r = ~b;
      default: begin valid = 0; wf = 0; end
    endcase
    if (!pass || !valid) r = 0;
    e = pass && valid && (op != 4'hB);
    nf = f;
    if (pass && valid && wf && (sb || op == 4'hB)) nf = {r[31], r == 0, nc, nv};
  endfunction

  task automatic drive(input logic [3:0] op, input logic [3:0] cnd, input logic sb,
                       input logic [2:0] sc, input logic [15:0] imv,
                       input logic [31:0] a, input logic [31:0] b);
    opcode = op; cond = cnd; sbit = sb; srcontrol = sc; imvalue = imv; in1 = a; in2 = b;
    model(op, cnd, sb, sc, imv, a, b, mf, er, ee, enf);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      mf = 4'b0000; ma = 16'h0000;
    end else begin
      mf = enf;
      if (sel_add_bus) ma = address_add_bus_in;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; sel_add_bus = 0; address_add_bus_in = 16'h0;
    drive(4'h0, 4'hE, 0, 3'b0, 16'h0, 32'h0, 32'h0);
    tick();
    rst = 0;
    n_cmp++;
    if (flags !== 4'b0000) begin n_err++; $display("FAIL reset_flags got=%b exp=0000", flags); end
    n_cmp++;
    if (address_out !== 16'h0) begin n_err++; $display("FAIL reset_addr got=%h exp=0000", address_out); end
  endtask

  typedef struct {
    logic [3:0] op, cnd; logic sb; logic [2:0] sc; logic [15:0] imv; logic [31:0] a, b;
  } vec_t;

  task automatic test_vectors();
    vec_t v[$];
    v.push_back('{4'h1, 4'hE, 1, 3'b000, 16'h0000, 32'd5, 32'd7});
    v.push_back('{4'h2, 4'hE, 1, 3'b000, 16'h0000, 32'd3, 32'd3});
    v.push_back('{4'h7, 4'h0, 0, 3'b000, 16'h1234, 32'h0, 32'h0});
    v.push_back('{4'h1, 4'hE, 1, 3'b000, 16'h0000, 32'h7FFFFFFF, 32'd1});
    v.push_back('{4'h7, 4'h1, 0, 3'b000, 16'h5555, 32'h0, 32'h0});
    v.push_back('{4'hA, 4'hE, 1, 3'b101, 16'h0004, 32'h8000000F, 32'h0});
    v.push_back('{4'hA, 4'hE, 1, 3'b010, 16'h0000, 32'h80000000, 32'd1});
    v.push_back('{4'hA, 4'hE, 1, 3'b000, 16'h0000, 32'h0, 32'd0});
    v.push_back('{4'hA, 4'hE, 1, 3'b100, 16'h001F, 32'h00000003, 32'h0});
    v.push_back('{4'hA, 4'hE, 1, 3'b111, 16'h0001, 32'h00000001, 32'h0});
    v.push_back('{4'hB, 4'hE, 0, 3'b000, 16'h0000, 32'd1, 32'd2});
    v.push_back('{4'hF, 4'hE, 1, 3'b000, 16'h0000, 32'd9, 32'd9});
    v.push_back('{4'h1, 4'hF, 1, 3'b000, 16'h0000, 32'd1, 32'd1});
    v.push_back('{4'h1, 4'hE, 0, 3'b000, 16'h0000, 32'hFFFFFFFF, 32'd1});
    v.push_back('{4'hD, 4'hE, 1, 3'b000, 16'h0001, 32'h80000000, 32'h0});
    for (int i = 0; i < v.size(); i++) begin
      drive(v[i].op, v[i].cnd, v[i].sb, v[i].sc, v[i].imv, v[i].a, v[i].b);
      #1;
      if (v[i].op != 4'hB) begin
        n_cmp++;
        if (result !== er) begin n_err++; $display("FAIL vec%0d_result got=%h exp=%h", i, result, er); end
      end
      n_cmp++;
      if (exec !== ee) begin n_err++; $display("FAIL vec%0d_exec got=%b exp=%b", i, exec, ee); end
      tick();
      n_cmp++;
      if (flags !== mf) begin n_err++; $display("FAIL vec%0d_flags got=%b exp=%b", i, flags, mf); end
      if (i == 0 || i == 1 || i == 3) begin
        n_cmp++;
        if (flags !== ((i == 0) ? 4'b0000 : (i == 1) ? 4'b0110 : 4'b1001)) begin
          n_err++; $display("FAIL vec%0d_flags_const got=%b", i, flags);
        end
      end
    end
  endtask

  task automatic test_address();
    drive(4'h0, 4'hE, 0, 3'b0, 16'h0, 32'h0, 32'h0);
    sel_add_bus = 1; address_add_bus_in = 16'h00AB;
    tick();
    n_cmp++;
    if (address_out !== 16'h00AB) begin n_err++; $display("FAIL addr_load got=%h exp=00ab", address_out); end
    sel_add_bus = 0; address_add_bus_in = 16'h1111;
    tick();
    n_cmp++;
    if (address_out !== 16'h00AB) begin n_err++; $display("FAIL addr_hold got=%h exp=00ab", address_out); end
    rst = 1;
    tick();
    rst = 0;
    n_cmp++;
    if (address_out !== 16'h0) begin n_err++; $display("FAIL addr_rst got=%h exp=0000", address_out); end
  endtask

  task automatic test_reset_priority();
    drive(4'h1, 4'hE, 1, 3'b0, 16'h0, 32'h7FFFFFFF, 32'd1);
    tick();
    rst = 1; sel_add_bus = 1; address_add_bus_in = 16'h0077;
    drive(4'h1, 4'hE, 1, 3'b0, 16'h0, 32'h7FFFFFFF, 32'd1);
    tick();
    rst = 0; sel_add_bus = 0;
    n_cmp++;
    if (flags !== 4'b0000) begin n_err++; $display("FAIL rstprio_flags got=%b exp=0000", flags); end
    n_cmp++;
    if (address_out !== 16'h0) begin n_err++; $display("FAIL rstprio_addr got=%h exp=0000", address_out); end
  endtask

  task automatic test_mul();
    drive(4'h3, 4'hE, 1, 3'b0, 16'h0, 32'h00010000, 32'h00010000);
    #1;
    n_cmp++;
    if (result !== 32'h0) begin n_err++; $display("FAIL mul_result got=%h exp=00000000", result); end
    n_cmp++;
    if (exec !== ee) begin n_err++; $display("FAIL mul_exec got=%b exp=%b", exec, ee); end
    tick();
    n_cmp++;
    if (flags !== mf) begin n_err++; $display("FAIL mul_flags got=%b exp=%b", flags, mf); end
    drive(4'h3, 4'hE, 1, 3'b0, 16'h0, 32'h0001_2345, 32'h0000_0100);
    #1;
    n_cmp++;
    if (result !== er) begin n_err++; $display("FAIL mul2_result got=%h exp=%h", result, er); end
    tick();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      sel_add_bus = 1'($urandom_range(0, 1));
      address_add_bus_in = 16'($urandom);
      drive(4'($urandom_range(0, 15)),
            ($urandom_range(0, 1) != 0) ? 4'hE : 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
            pick(), pick());
      #1;
      if (opcode != 4'hB) begin
        n_cmp++;
        if (result !== er) begin
          n_err++; $display("FAIL rnd%0d_result op=%h cond=%h got=%h exp=%h", i, opcode, cond, result, er);
        end
      end
      n_cmp++;
      if (exec !== ee) begin n_err++; $display("FAIL rnd%0d_exec op=%h got=%b exp=%b", i, opcode, exec, ee); end
      tick();
      n_cmp++;
      if (flags !== mf) begin n_err++; $display("FAIL rnd%0d_flags op=%h got=%b exp=%b", i, opcode, flags, mf); end
      n_cmp++;
      if (address_out !== ma) begin n_err++; $display("FAIL rnd%0d_addr got=%h exp=%h", i, address_out, ma); end
    end
  endtask

  initial begin
    rst = 1; sel_add_bus = 0; address_add_bus_in = 0;
    opcode = 0; cond = 4'hE; sbit = 0; srcontrol = 0; imvalue = 0; in1 = 0; in2 = 0;
    mf = 4'b0000; ma = 16'h0;
    @(negedge clk);
    test_reset();
    test_vectors();
    test_address();
    test_reset_priority();
    test_mul();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
